// File: rtl/pm32_pkg.sv
// Shared constants and FSM encoding for the pm32 serial shift-add multiplier.
package pm32_pkg;
    localparam int SIZE  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/pm32_ctrl.sv
// Sequencer for pm32: IDLE/BUSY/DONE FSM with bit counter, emitting load/shift/finish strobes.
//   state | meaning
//   IDLE  | no operation since reset, waiting for start
//   BUSY  | consuming one multiplier bit per clock
//   DONE  | product valid, done held high, waiting for start
module pm32_ctrl
    import pm32_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic load_o,
    output logic shift_o,
    output logic finish_o,
    output logic done_o
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    assign load_o   = !rst && start && (state_q != BUSY);
    assign shift_o  = (state_q == BUSY);
    assign finish_o = shift_o && (cnt_q == LAST_BIT);
    assign done_o   = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/pm32.sv
// Unsigned 32x32 serial-parallel shift-add multiplier, one multiplier bit per clock, LSB first.
module pm32 #(
    parameter int SIZE = pm32_pkg::SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SIZE-1:0]     mc,
    input  logic [SIZE-1:0]     mp,
    output logic [2*SIZE-1:0]   p,
    output logic                done
);
    import pm32_pkg::*;

    logic load, shift, finish;

    logic [SIZE-1:0]   mc_q, mc_d;
    logic [SIZE-1:0]   mpsr_q, mpsr_d;
    logic [SIZE:0]     acc_q, acc_d;
    logic [SIZE:0]     sum;
    logic [2*SIZE-1:0] p_q, p_d;

    pm32_ctrl u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_o   (load),
        .shift_o  (shift),
        .finish_o (finish),
        .done_o   (done)
    );

    // acc_q[SIZE] is always zero after a shift, so the 33-bit sum cannot overflow.
    assign sum = acc_q + {1'b0, (mpsr_q[0] ? mc_q : {SIZE{1'b0}})};

    always_comb begin
        mc_d   = mc_q;
        mpsr_d = mpsr_q;
        acc_d  = acc_q;
        p_d    = p_q;
        if (load) begin
            mc_d   = mc;
            mpsr_d = mp;
            acc_d  = '0;
        end else if (shift) begin
            acc_d  = {1'b0, sum[SIZE:1]};
            mpsr_d = {sum[0], mpsr_q[SIZE-1:1]};
            // Final product is the shifted {acc, multiplier} pair of this last step.
            if (finish) p_d = {sum, mpsr_q[SIZE-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_q   <= '0;
            mpsr_q <= '0;
            acc_q  <= '0;
            p_q    <= '0;
        end else begin
            mc_q   <= mc_d;
            mpsr_q <= mpsr_d;
            acc_q  <= acc_d;
            p_q    <= p_d;
        end
    end

    assign p = p_q;
endmodule

// File: tb/tb_pm32.sv
// Self-checking bench for pm32: directed scenarios plus randomized traffic against a latency/product model.
module tb_pm32;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] mc, mp;
    logic [63:0] p;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: an operation is a pending product plus cycles left until it appears
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_p    = '0;
    logic        m_done = 1'b0;

    pm32 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mc    (mc),
        .mp    (mp),
        .p     (p),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic [31:0] a, input logic [31:0] b);
        rst   = r;
        start = s;
        mc    = a;
        mp    = b;
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0;
            m_left = 0;
            m_p    = '0;
            m_done = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_p    = m_res;
                m_done = 1'b1;
            end
        end else if (s) begin
            m_busy = 1'b1;
            m_left = 32;
            m_res  = 64'(a) * 64'(b);
            m_done = 1'b0;
        end
        #1;
        check("p", p, m_p);
        check("done", {63'd0, done}, {63'd0, m_done});
    endtask

    // one accepted start followed by 32 cycles of noisy operand inputs
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        tick(1'b0, 1'b1, a, b);
        for (int i = 0; i < 32; i++) tick(1'b0, 1'b0, $urandom, $urandom);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; mc = '0; mp = '0;

        tick(1'b1, 1'b0, 32'd0, 32'd0);
        tick(1'b1, 1'b1, 32'd7, 32'd7);
        check("reset_p", p, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);

        tick(1'b0, 1'b1, 32'd56, 32'd101);
        for (int i = 0; i < 31; i++) tick(1'b0, 1'b0, $urandom, $urandom);
        check("lat31_done_low", {63'd0, done}, 64'd0);
        tick(1'b0, 1'b0, 32'd0, 32'd0);
        check("lat32_done", {63'd0, done}, 64'd1);
        check("p_56x101", p, 64'd5656);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, $urandom, $urandom);
        check("done_hold", {63'd0, done}, 64'd1);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("p_max", p, 64'hFFFF_FFFE_0000_0001);
        run_op(32'd0, 32'h1234_5678);
        check("p_zero", p, 64'd0);
        check("done_zero", {63'd0, done}, 64'd1);
        run_op(32'd1, 32'hFFFF_FFFF);
        check("p_one", p, 64'h0000_0000_FFFF_FFFF);

        tick(1'b0, 1'b1, 32'd3, 32'd7);
        for (int i = 1; i <= 32; i++) begin
            if (i == 10) tick(1'b0, 1'b1, 32'd9, 32'd9);
            else         tick(1'b0, 1'b0, $urandom, $urandom);
        end
        check("p_ignore_start", p, 64'd21);

        tick(1'b0, 1'b1, 32'd5, 32'd6);
        for (int i = 1; i < 15; i++) tick(1'b0, 1'b0, $urandom, $urandom);
        tick(1'b1, 1'b0, 32'd5, 32'd6);
        check("abort_p", p, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, $urandom, $urandom);
        check("abort_no_done", {63'd0, done}, 64'd0);
        run_op(32'd5, 32'd6);
        check("p_after_abort", p, 64'd30);

        tick(1'b0, 1'b1, 32'd2, 32'd2);
        check("restart_done_low", {63'd0, done}, 64'd0);
        check("restart_p_hold", p, 64'd30);
        for (int i = 0; i < 31; i++) tick(1'b0, 1'b0, $urandom, $urandom);
        check("restart_p_still", p, 64'd30);
        tick(1'b0, 1'b0, $urandom, $urandom);
        check("p_2x2", p, 64'd4);

        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                 pick_operand(), pick_operand());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pm32.md
PM32 -- requirements
Module: pm32

Interface
REQ-001 Parameter: SIZE, default 32, operand width; product width is 2*SIZE; only SIZE=32 need be supported.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-005 start  input  1  request a multiplication; sampled on clk rising edge.
REQ-006 mc  input  32  multiplicand, unsigned.
REQ-007 mp  input  32  multiplier, unsigned.
REQ-008 p  output  64  product of the last completed operation.
REQ-009 done  output  1  high while p holds a valid, newly completed product.

Function
REQ-010 The block SHALL compute p = mc * mp, unsigned, full 64-bit result, no truncation or overflow.
REQ-011 Serial-parallel shift-add, one multiplier bit per clock, LSB first:
- mc applied in parallel
- add mc into a 33-bit accumulator when the current mp bit is 1
- shift {accumulator, multiplier} right by one.
REQ-012 FSM states SHALL be IDLE, BUSY and DONE.
REQ-013 IDLE/DONE with start=1 at edge k: latch mc and mp, clear accumulator, clear the 6-bit bit counter, clear done, enter BUSY.
REQ-014 BUSY: process exactly one bit per edge, for 32 edges (k+1..k+32).
REQ-015 On edge k+32: load the final product into p, set done=1, enter DONE; latency from the start sample to done is exactly 32 cycles.
REQ-016 DONE: hold p and done=1 stably until the next accepted start or reset.
REQ-017 IDLE/DONE with start=0: no state change.
REQ-018 start during BUSY SHALL be ignored, with no effect on the running operation.
REQ-019 A start held high for several cycles SHALL be accepted only at its first sampled edge outside BUSY.
REQ-020 After acceptance, changes on mc/mp SHALL NOT affect the running operation.
REQ-021 p SHALL change only at a completion edge or on reset, never during BUSY.
REQ-022 start at edge k in DONE: done SHALL drop after edge k and p keeps the old value until the new completion at k+32.
REQ-023 Zero operands SHALL still take the full 32 cycles; no early termination.

Reset
REQ-024 rst=1 at an edge forces state IDLE, p=0, done=0, accumulator=0, counter=0, regardless of state.
REQ-025 rst=1 during BUSY SHALL abort the operation with no completion and no done pulse.
REQ-026 rst has priority over a simultaneous start; start is ignored at that edge.
REQ-027 The first start SHALL be accepted at the first edge after rst deasserts.

Structure
REQ-028 A shared package pm32_pkg SHALL hold: SIZE (32), the counter width (6), and the FSM state encodings IDLE/BUSY/DONE.
REQ-029 pm32 SHALL contain one sub-module, pm32_ctrl: FSM plus bit counter, outputting load, shift and finish strobes.
REQ-030 The datapath SHALL stay in pm32: operand registers, 33-bit adder, shift register, p register.

Verification
REQ-031 rst for 2 cycles; then mc=56, mp=101, start for 1 cycle -> done=1 exactly 32 cycles after the start edge; p=5656.
REQ-032 mc=0xFFFFFFFF, mp=0xFFFFFFFF -> p=0xFFFFFFFE00000001.
REQ-033 mc=0, mp=0x12345678 -> p=0 after 32 cycles; then mc=1, mp=0xFFFFFFFF -> p=0x00000000FFFFFFFF.
REQ-034 Start mc=3, mp=7; at cycle 10 pulse start with mc=9, mp=9 and also change mc/mp -> p=21, the second start ignored.
REQ-035 Start mc=5, mp=6; assert rst at cycle 15 -> p=0, done=0, no later done; then mc=5, mp=6 after reset -> p=30.
REQ-036 After done with p=30, start mc=2, mp=2 from DONE -> done low next cycle, p stays 30 until completion, then p=4.
